pic_host_ctrl: RTL
==================

// Module: pic_host_ctrl
// PURPOSE
//  Clocked host-side bus master for the PIC: converts local command requests into CS/WR/RD/A0 bus
//  cycles (ICW/OCW writes, IRR/ISR/IMR reads) and answers INT with the two-pulse INTA sequence.
//  Captures the vector the PIC drives on the second INTA and hands it to the local CPU model.
//  Sits between the processor model and PIC; tristate D is resolved at top level.
// PARAMETERS
//  STROBE_CYC  2  clock cycles each WR/RD/INTA strobe is held low (legal >= 1)
//  GAP_CYC     1  clock cycles all strobes held high between strobes/operations (legal >= 1)
// PORTS
//  clk         in   1  single clock, all state on rising edge
//  rst_n       in   1  asynchronous active-low reset
//  cmd_valid   in   1  local command request
//  cmd_ready   out  1  command accepted when cmd_valid & cmd_ready
//  cmd_rd      in   1  1 = read cycle, 0 = write cycle
//  cmd_a0      in   1  A0 value for the cycle
//  cmd_wdata   in   8  write data
//  rsp_valid   out  1  one-cycle pulse: read data valid
//  rsp_rdata   out  8  captured read data (holds until next read)
//  int_en      in   1  1 = service INT; 0 = ignore INT
//  vec_valid   out  1  one-cycle pulse: vector captured
//  vec_data    out  8  captured vector (holds until next vector)
//  INT         in   1  interrupt from PIC, asynchronous to clk
//  CS, WR, RD  out  1  active-low chip select / write / read strobes
//  A0          out  1  address bit
//  INTA        out  1  active-low interrupt acknowledge
//  D_out       out  8  bus drive value
//  D_oe        out  1  1 = drive D with D_out
//  D_in        in   8  resolved bus value
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): CS=WR=RD=INTA=1, A0=0, D_oe=0, D_out=0,
//   cmd_ready=0, rsp_valid=vec_valid=0, rsp_rdata=vec_data=0, FSM=IDLE, counters=0, sync flops=0.
//  INT passes a 2-flop synchronizer (int_s); no other input is synchronized.
//  FSM: IDLE, WR_STB, RD_STB, INTA1, GAP1, INTA2, GAP_END (+EOI_STB with macro).
//  IDLE: cmd_ready = ~(int_s & int_en). int_s & int_en -> INTA1 (priority over cmd_valid);
//   else accepted write -> WR_STB, accepted read -> RD_STB; A0/D_out registered at acceptance.
//  WR_STB: CS=0, WR=0, D_oe=1 for STROBE_CYC cycles -> GAP_END.
//  RD_STB: CS=0, RD=0, D_oe=0 for STROBE_CYC cycles; D_in sampled on last strobe cycle into
//   rsp_rdata; rsp_valid pulses the first GAP_END cycle -> GAP_END.
//  INTA1: INTA=0, CS=1, D_oe=0 for STROBE_CYC -> GAP1 (GAP_CYC, INTA=1) -> INTA2.
//  INTA2: INTA=0 for STROBE_CYC; D_in sampled last cycle into vec_data; vec_valid pulses first
//   cycle after -> GAP_END (or EOI_STB with macro).
//  GAP_END: all strobes high, D_oe=0, GAP_CYC cycles -> IDLE.
//  Latency: INT rise -> INTA low in 3-4 clk (2 sync + IDLE decision). Write accept -> WR low next clk.
//  INT dropping after INTA1 starts: sequence completes, vector (spurious 7 etc.) still delivered.
//  INT still high on return to IDLE: new INTA sequence starts (level behaviour owned by PIC).
//  int_en deasserted mid-sequence: sequence completes; only IDLE checks int_en.
//  cmd_valid while busy: cmd_ready=0, request held by sender, no loss.
//  Strobe and gap counters: $clog2(max(STROBE_CYC,GAP_CYC)+1) bits, reload on state entry, no wrap.
//  Never two strobes low together; CS low only with WR or RD.
// CONFIGURATION
//  PIC_HOST_AUTO_EOI_EN defined: after vec_valid, EOI_STB issues a write cycle A0=0, D_out=8'h20
//   (non-specific EOI OCW2) with normal WR_STB timing, then GAP_END.
//  Not defined: no EOI_STB state; EOI is issued by the local CPU as a normal write command.
// STRUCTURE
//  pic_host_defs.vh: state encodings (localparam), OCW2_NS_EOI = 8'h20, strobe-width defaults.
//  Sub-module pic_int_sync: 2-flop synchronizer for INT, reset to 0 by rst_n.
// TESTING
//  Write cmd a0=0 wdata=8'hB3 -> CS,WR low exactly 2 clk, D_oe=1, D_out=B3, A0=0; then 1 clk gap.
//  Read cmd a0=0, D_in=8'h28 during strobe -> RD low 2 clk, rsp_valid 1 clk, rsp_rdata=28.
//  INT=1, int_en=1, D_in=8'h33 on 2nd pulse -> two 2-clk INTA pulses, 1-clk gap, vec_data=33.
//  INT and cmd_valid rise same cycle -> cmd_ready=0, INTA sequence first, write follows after gap.
//  rst_n low mid-WR strobe -> CS/WR/INTA high and D_oe=0 same cycle, FSM IDLE after release.
//  Macro defined, vector 8'h34 -> vec_valid, then WR cycle A0=0 D_out=20; undefined -> no WR cycle.

Source files
------------

// File: rtl/pic_host_ctrl_pkg.sv
// Shared state encoding and bus constants for the PIC host-side bus master.
// The auto-EOI state exists only when PIC_HOST_AUTO_EOI_EN is defined.
package pic_host_ctrl_pkg;

    localparam int         STROBE_CYC_DEF = 2;
    localparam int         GAP_CYC_DEF    = 1;
    localparam logic [7:0] OCW2_NS_EOI    = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_STB  = 3'd1,
        ST_RD_STB  = 3'd2,
        ST_INTA1   = 3'd3,
        ST_GAP1    = 3'd4,
        ST_INTA2   = 3'd5,
        ST_GAP_END = 3'd6
`ifdef PIC_HOST_AUTO_EOI_EN
        ,
        ST_EOI_STB = 3'd7
`endif
    } host_state_e;

endpackage

// File: rtl/pic_int_sync.sv
// Two-flop synchronizer bringing the PIC INT line into the clk domain.
module pic_int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/pic_host_ctrl.sv
// Host-side PIC bus master: command read/write cycles and the two-pulse INTA sequence.
// Define PIC_HOST_AUTO_EOI_EN to append a non-specific EOI write after every vector.
module pic_host_ctrl
    import pic_host_ctrl_pkg::*;
#(
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int GAP_CYC    = GAP_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic       int_en,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    input  logic       INT,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic       A0,
    output logic       INTA,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in
);

    localparam int MAX_CYC = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

    host_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             int_s, int_req, accept, cnt_done;
    logic             wr_phase_nxt, rd_phase_nxt, inta_phase_nxt;
    logic             rd_last, vec_last;
`ifdef PIC_HOST_AUTO_EOI_EN
    logic             eoi_pend, eoi_pend_nxt, eoi_start;
`endif

    pic_int_sync u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (INT),
        .sync_out (int_s)
    );

    assign int_req   = int_s & int_en;
    assign cnt_done  = (cnt == '0);
    // Gated by rst_n so the handshake is closed while reset is held.
    assign cmd_ready = rst_n & (state == ST_IDLE) & ~int_req;
    assign accept    = cmd_valid & cmd_ready;
    assign rd_last   = (state == ST_RD_STB) & cnt_done;
    assign vec_last  = (state == ST_INTA2) & cnt_done;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef PIC_HOST_AUTO_EOI_EN
        eoi_pend_nxt = eoi_pend;
        eoi_start    = 1'b0;
`endif
        if (!cnt_done) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
        case (state)
            ST_IDLE: begin
                if (int_req) begin
                    state_nxt = ST_INTA1;
                    cnt_nxt   = STB_LOAD;
                end else if (accept) begin
                    state_nxt = cmd_rd ? ST_RD_STB : ST_WR_STB;
                    cnt_nxt   = STB_LOAD;
                end
            end
            ST_WR_STB, ST_RD_STB: begin
                if (cnt_done) begin
                    state_nxt = ST_GAP_END;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            ST_INTA1: begin
                if (cnt_done) begin
                    state_nxt = ST_GAP1;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            ST_GAP1: begin
                if (cnt_done) begin
                    state_nxt = ST_INTA2;
                    cnt_nxt   = STB_LOAD;
                end
            end
            ST_INTA2: begin
                if (cnt_done) begin
                    state_nxt = ST_GAP_END;
                    cnt_nxt   = GAP_LOAD;
`ifdef PIC_HOST_AUTO_EOI_EN
                    eoi_pend_nxt = 1'b1;
`endif
                end
            end
            ST_GAP_END: begin
                if (cnt_done) begin
`ifdef PIC_HOST_AUTO_EOI_EN
                    // The EOI write still gets a full gap after INTA2.
                    if (eoi_pend) begin
                        state_nxt    = ST_EOI_STB;
                        cnt_nxt      = STB_LOAD;
                        eoi_pend_nxt = 1'b0;
                        eoi_start    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef PIC_HOST_AUTO_EOI_EN
            ST_EOI_STB: begin
                if (cnt_done) begin
                    state_nxt = ST_GAP_END;
                    cnt_nxt   = GAP_LOAD;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Strobes are registered from the next state so the pins never glitch.
`ifdef PIC_HOST_AUTO_EOI_EN
        wr_phase_nxt = (state_nxt == ST_WR_STB) | (state_nxt == ST_EOI_STB);
`else
        wr_phase_nxt = (state_nxt == ST_WR_STB);
`endif
        rd_phase_nxt   = (state_nxt == ST_RD_STB);
        inta_phase_nxt = (state_nxt == ST_INTA1) | (state_nxt == ST_INTA2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            CS        <= 1'b1;
            WR        <= 1'b1;
            RD        <= 1'b1;
            INTA      <= 1'b1;
            A0        <= 1'b0;
            D_oe      <= 1'b0;
            D_out     <= 8'h00;
            rsp_valid <= 1'b0;
            vec_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            vec_data  <= 8'h00;
`ifdef PIC_HOST_AUTO_EOI_EN
            eoi_pend  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            CS        <= ~(wr_phase_nxt | rd_phase_nxt);
            WR        <= ~wr_phase_nxt;
            RD        <= ~rd_phase_nxt;
            INTA      <= ~inta_phase_nxt;
            D_oe      <= wr_phase_nxt;
            rsp_valid <= rd_last;
            vec_valid <= vec_last;
            if (rd_last) begin
                rsp_rdata <= D_in;
            end
            if (vec_last) begin
                vec_data <= D_in;
            end
            if (accept) begin
                A0    <= cmd_a0;
                D_out <= cmd_wdata;
            end
`ifdef PIC_HOST_AUTO_EOI_EN
            else if (eoi_start) begin
                A0    <= 1'b0;
                D_out <= OCW2_NS_EOI;
            end
            eoi_pend <= eoi_pend_nxt;
`endif
        end
    end

endmodule
